// File: rtl/hsv_ui_pkg.sv
// Mode codes shared by the front-panel sequencer and the HSV value generator.
// Codes 7..15 are never produced by either side.
package hsv_ui_pkg;
    localparam int SOST_W = 4;

    typedef logic [SOST_W-1:0] sost_t;

    localparam sost_t SOST_FIXED  = 4'd0;
    localparam sost_t SOST_STEP60 = 4'd1;
    localparam sost_t SOST_SWEEP  = 4'd2;
    localparam sost_t SOST_ADJ_H  = 4'd3;
    localparam sost_t SOST_ADJ_S  = 4'd4;
    localparam sost_t SOST_ADJ_V  = 4'd5;
    localparam sost_t SOST_HOLD   = 4'd6;
    localparam sost_t SOST_LAST   = 4'd6;

    // Manual stepping walks every mode and wraps after hold.
    function automatic sost_t next_manual(input sost_t s);
        return (s >= SOST_LAST) ? SOST_FIXED : sost_t'(s + 1'b1);
    endfunction

    // Auto-demo only cycles the three automatic hue modes.
    function automatic sost_t next_auto(input sost_t s);
        return (s >= SOST_SWEEP) ? SOST_FIXED : sost_t'(s + 1'b1);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one raw push-button.
// rise/fall are registered pulses aligned with the cycle the level changes.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // The edge that would bring the count to DEBOUNCE_CYCLES flips the level instead.
    assign flip = (sync2 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= flip && !level;
            fall  <= flip && level;
            if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else if (sync2 != level) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/hsv_mode_sequencer.sv
// Front-panel mode controller: short/long btn1 presses and optional auto-demo
// step the sost mode code; btn2 is passed through only in the adjust modes.
module hsv_mode_sequencer
    import hsv_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int AUTO_DWELL      = 500_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn1,
    input  logic              btn2,
    input  logic [3:0]        sw,
    output logic [SOST_W-1:0] sost,
    output logic              btn2_out,
    output logic              mode_changed
);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int DWELL_W = $clog2(AUTO_DWELL + 1);

    logic               b1_level, b1_rise, b1_fall;
    logic               b2_level;
    logic               unused_b2_rise, unused_b2_fall, unused_sw;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               long_press;
    logic [DWELL_W-1:0] dwell;
    logic               long_hit, short_hit, auto_active, auto_hit;
    sost_t              sost_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk   (clk),
        .reset (reset),
        .din   (btn1),
        .level (b1_level),
        .rise  (b1_rise),
        .fall  (b1_fall)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk   (clk),
        .reset (reset),
        .din   (btn2),
        .level (b2_level),
        .rise  (unused_b2_rise),
        .fall  (unused_b2_fall)
    );

    // btn2 edges and the remaining switch bits have no consumer in this block.
    assign unused_sw = ^{sw[3:2], sw[0]};

    assign long_hit    = b1_level && !b1_rise && !long_press
                         && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign short_hit   = b1_fall && !long_press;
    assign auto_active = sw[1] && (sost <= SOST_SWEEP);
    assign auto_hit    = auto_active && (dwell == DWELL_W'(AUTO_DWELL - 1));

    // Press tracker: hold_cnt counts cycles of debounced-high including the rise cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else if (b1_rise) begin
            hold_cnt   <= HOLD_W'(1);
            long_press <= 1'b0;
        end else if (b1_level && (hold_cnt != HOLD_W'(HOLD_CYCLES))) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (long_hit)
                long_press <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dwell <= '0;
        else if (!auto_active || auto_hit || b1_rise || b1_fall || (sost_next != sost))
            dwell <= '0;
        else
            dwell <= dwell + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sost         <= SOST_FIXED;
            mode_changed <= 1'b0;
        end else begin
            sost         <= sost_next;
            mode_changed <= (sost_next != sost);
        end
    end

    // Long press outranks short press, which outranks the auto step.
    always_comb begin
        sost_next = sost;
        if (long_hit)
            sost_next = SOST_FIXED;
        else if (short_hit)
            sost_next = next_manual(sost);
        else if (auto_hit)
            sost_next = next_auto(sost);
    end

    always_comb begin
        btn2_out = b2_level && (sost >= SOST_ADJ_H) && (sost <= SOST_ADJ_V);
    end
endmodule

// File: tb/tb_hsv_mode_sequencer.sv
// Bench for hsv_mode_sequencer: event-time reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_hsv_mode_sequencer;
    localparam int DEB   = 4;
    localparam int HOLD  = 20;
    localparam int DWELL = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn1;
    logic       btn2;
    logic [3:0] sw;
    logic [3:0] sost;
    logic       btn2_out;
    logic       mode_changed;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    hsv_mode_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .AUTO_DWELL     (DWELL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn1         (btn1),
        .btn2         (btn2),
        .sw           (sw),
        .sost         (sost),
        .btn2_out     (btn2_out),
        .mode_changed (mode_changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: remembers when things happened (edge numbers) rather
    // than keeping counters; a debounced level flips once the last DEB
    // synchronised samples all disagree with it.
    typedef struct packed {
        int          n;
        int          t_rise;
        int          t_fall;
        int          t_clr;
        bit          long_fired;
        bit [DEB+1:0] h1;
        bit [DEB+1:0] h2;
        bit          l1;
        bit          l2;
        int          sost;
        bit          mc;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.n = 0;  r.t_rise = -1000;  r.t_fall = -1000;  r.t_clr = 0;
        r.long_fired = 1'b0;  r.h1 = '0;  r.h2 = '0;  r.l1 = 1'b0;  r.l2 = 1'b0;
        r.sost = 0;  r.mc = 1'b0;
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input bit b1, input bit b2,
                                           input bit auto_en);
        mstate_t r = s;
        bit active, long_due, short_due, btn_evt, auto_due;
        r.n       = s.n + 1;
        active    = auto_en && (s.sost <= 2);
        long_due  = s.l1 && !s.long_fired && (r.n == s.t_rise + HOLD);
        short_due = (s.t_fall == r.n - 1) && !s.long_fired;
        btn_evt   = (s.t_rise == r.n - 1) || (s.t_fall == r.n - 1);
        auto_due  = active && (r.n - s.t_clr == DWELL);
        if (long_due) begin
            r.sost = 0;
            r.long_fired = 1'b1;
        end else if (short_due) begin
            r.sost = (s.sost + 1) % 7;
        end else if (auto_due) begin
            r.sost = (s.sost + 1) % 3;
        end
        r.mc = (r.sost != s.sost);
        if (!active || btn_evt || auto_due || r.mc)
            r.t_clr = r.n;
        r.h1 = {s.h1[DEB:0], b1};
        r.h2 = {s.h2[DEB:0], b2};
        if (r.h1[DEB+1:2] == {DEB{!s.l1}}) begin
            r.l1 = !s.l1;
            if (r.l1) begin
                r.t_rise = r.n;
                r.long_fired = 1'b0;
            end else begin
                r.t_fall = r.n;
            end
        end
        if (r.h2[DEB+1:2] == {DEB{!s.l2}})
            r.l2 = !s.l2;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)
            ms <= model_reset();
        else
            ms <= model_step(ms, btn1, btn2, sw[1]);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("model_sost", int'(sost), ms.sost);
            check("model_mode_changed", int'(mode_changed), int'(ms.mc));
            check("model_btn2_out", int'(btn2_out),
                  int'(ms.l2 && (ms.sost >= 3) && (ms.sost <= 5)));
        end
    end

    // Waits (bounded) for sost to change; lat = -1 when the bound expires.
    task automatic wait_change(input int bound, output int lat, output int mc, output int b2);
        int start;
        logic [3:0] s0;
        start = cyc;  s0 = sost;  lat = -1;  mc = -1;  b2 = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sost != s0) begin
                lat = cyc - start;
                mc  = int'(mode_changed);
                b2  = int'(btn2_out);
                break;
            end
        end
    endtask

    task automatic press(input int high, output int lat, output int mc, output int b2);
        btn1 = 1'b1;
        repeat (high) @(negedge clk);
        btn1 = 1'b0;
        wait_change(20, lat, mc, b2);
        repeat (3) @(negedge clk);
    endtask

    task automatic goto_mode(input int target);
        int lat, mc, b2;
        for (int g = 0; g < 8; g++) begin
            if (int'(sost) == target) break;
            press(10, lat, mc, b2);
        end
        check("goto_mode", int'(sost), target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, mc, b2, start;
        reset = 1'b1;  btn1 = 1'b0;  btn2 = 1'b0;  sw = 4'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_sost", int'(sost), 0);
        check("reset_btn2_out", int'(btn2_out), 0);
        check("reset_mode_changed", int'(mode_changed), 0);
        repeat (10) @(negedge clk);
        check("idle_quiet", int'(sost), 0);

        // Seven short presses walk the full mode ring.
        for (int i = 0; i < 7; i++) begin
            press(10, lat, mc, b2);
            check("short_latency", lat, 7);
            check("short_pulse", mc, 1);
            check("short_sost", int'(sost), (i + 1) % 7);
        end

        // Glitches.
        btn1 = 1'b1;
        repeat (3) @(negedge clk);
        btn1 = 1'b0;
        repeat (15) @(negedge clk);
        check("glitch_rejected", int'(sost), 0);
        btn1 = 1'b1;  @(negedge clk);
        btn1 = 1'b0;  @(negedge clk);
        btn1 = 1'b1;
        repeat (10) @(negedge clk);
        btn1 = 1'b0;
        wait_change(20, lat, mc, b2);
        check("bounce_latency", lat, 7);
        check("bounce_sost", int'(sost), 1);
        repeat (3) @(negedge clk);

        // Long press from mode 4.
        goto_mode(4);
        btn1 = 1'b1;
        wait_change(40, lat, mc, b2);
        check("long_latency", lat, 26);
        check("long_sost", int'(sost), 0);
        check("long_pulse", mc, 1);
        repeat (14) @(negedge clk);
        btn1 = 1'b0;
        repeat (15) @(negedge clk);
        check("long_release_no_advance", int'(sost), 0);

        // Auto-demo cycling.
        sw = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wait_change(40, lat, mc, b2);
            check("auto_interval", lat, DWELL);
            check("auto_sost", int'(sost), (k + 1) % 3);
        end
        sw = 4'b0000;
        repeat (2) @(negedge clk);
        sw = 4'b0010;
        repeat (12) @(negedge clk);
        press(10, lat, mc, b2);
        check("press_in_auto_single_step", int'(sost), 1);
        sw = 4'b0000;
        goto_mode(3);
        sw = 4'b0010;
        repeat (70) @(negedge clk);
        check("no_auto_in_adjust", int'(sost), 3);
        sw = 4'b0000;

        // btn2 gating.
        goto_mode(2);
        btn2 = 1'b1;
        repeat (10) @(negedge clk);
        check("btn2_gated_sweep", int'(btn2_out), 0);
        press(10, lat, mc, b2);
        check("btn2_enter_adj_sost", int'(sost), 3);
        check("btn2_open_same_cycle", b2, 1);
        press(10, lat, mc, b2);
        check("btn2_open_adj_s", b2, 1);
        press(10, lat, mc, b2);
        check("btn2_open_adj_v", b2, 1);
        press(10, lat, mc, b2);
        check("btn2_leave_adj_sost", int'(sost), 6);
        check("btn2_closed_same_cycle", b2, 0);
        btn2 = 1'b0;
        repeat (10) @(negedge clk);
        goto_mode(3);
        btn2 = 1'b1;  @(negedge clk);
        btn2 = 1'b0;  @(negedge clk);
        btn2 = 1'b1;
        start = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (btn2_out) begin
                lat = cyc - start;
                break;
            end
        end
        check("btn2_bounce_latency", lat, 6);

        // Asynchronous reset mid-cycle with both buttons held.
        btn1 = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_reset_btn2_out", int'(btn2_out), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_sost", int'(sost), 0);
        check("async_reset_btn2_out", int'(btn2_out), 0);
        check("async_reset_mode_changed", int'(mode_changed), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        btn1 = 1'b0;
        wait_change(20, lat, mc, b2);
        check("press_across_reset", int'(sost), 1);
        check("press_across_reset_latency", lat, 7);
        btn2 = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized mix of presses, glitches, btn2 activity and switch changes.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    btn1 = 1'b1;
                    repeat ($urandom_range(1, 30)) @(negedge clk);
                    btn1 = 1'b0;
                end
                1: begin
                    btn2 = ~btn2;
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                end
                2: repeat ($urandom_range(1, 40)) @(negedge clk);
                default: begin
                    sw = 4'($urandom_range(0, 15));
                    @(negedge clk);
                end
            endcase
        end
        btn1 = 1'b0;  btn2 = 1'b0;  sw = 4'd0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
